// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding, per-VC packet state and
// default link parameters used by the router output port.
package noc_pkg;

  localparam int DEFAULT_FLIT_WIDTH = 80;
  localparam int DEFAULT_FIFO_NUM   = 5;
  localparam int DEFAULT_BUF_DEPTH  = 4;

  // The flit type occupies the two most significant bits of a flit.
  localparam int FLIT_TYPE_W   = 2;
  localparam int FLIT_TYPE_MSB = DEFAULT_FLIT_WIDTH - 1;
  localparam int FLIT_TYPE_LSB = DEFAULT_FLIT_WIDTH - FLIT_TYPE_W;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FLIT_HEADTAIL = 2'b00,
    FLIT_HEAD     = 2'b01,
    FLIT_BODY     = 2'b10,
    FLIT_TAIL     = 2'b11
  } flit_type_e;

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_ACTIVE = 1'b1
  } vc_state_e;

  // A packet may only start on an idle VC and only continue on an active one.
  function automatic logic is_legal(vc_state_e state, flit_type_e ftype);
    if (state == VC_IDLE) return (ftype == FLIT_HEADTAIL) || (ftype == FLIT_HEAD);
    else                  return (ftype == FLIT_BODY) || (ftype == FLIT_TAIL);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Per-VC credit counter mirroring the free slots of one downstream VC FIFO.
// Starts full; an increment while already full saturates and flags overflow.
module credit_counter
  import noc_pkg::*;
#(
  parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH,
  localparam int CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic overflow
);

  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next credit value; simultaneous inc and dec cancel out.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cnt_d    = cnt_q;
    overflow = 1'b0;
    case ({inc, dec})
      2'b10: begin
        if (cnt_q == FULL) overflow = 1'b1;
        else               cnt_d    = cnt_q + CW'(1);
      end
      2'b01: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Credit register, restored to a full downstream FIFO on reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (!rst) cnt_q <= FULL;
    else      cnt_q <= cnt_d;
  end

  assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/outputport.sv
// Router output port: credit-based flow control towards the downstream
// inputport plus per-VC head/body/tail ordering enforcement.
// Optional feature: define OUTPORT_STATS_EN to add the 32-bit flit_cnt output.
module outputport
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH = DEFAULT_FLIT_WIDTH,
  parameter int FIFO_NUM   = DEFAULT_FIFO_NUM,
  parameter int BUF_DEPTH  = DEFAULT_BUF_DEPTH,
  localparam int VC_W      = (FIFO_NUM > 1) ? $clog2(FIFO_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] flit_in,
  input  logic                  flit_valid,
  input  logic [VC_W-1:0]       vc_sel,
  output logic                  flit_ready,
  input  logic [FIFO_NUM-1:0]   credit_in,
  output logic [FLIT_WIDTH-1:0] Flit_out,
  output logic [FIFO_NUM-1:0]   vcx_out,
  output logic [FIFO_NUM-1:0]   credit_avail,
  output logic [FIFO_NUM-1:0]   vc_busy,
  output logic                  proto_err
`ifdef OUTPORT_STATS_EN
  ,output logic [31:0]          flit_cnt
`endif
);

  // Index space of vc_sel, so out-of-range selects read a zero credit flag.
  localparam int VC_SPAN = 1 << VC_W;

  vc_state_e               vc_state_q [FIFO_NUM];
  logic [FIFO_NUM-1:0]     credit_nz;
  logic [FIFO_NUM-1:0]     credit_ovf;
  logic [FIFO_NUM-1:0]     credit_dec;
  logic [VC_SPAN-1:0]      credit_nz_ext;
  logic [FLIT_WIDTH-1:0]   flit_q;
  logic [FIFO_NUM-1:0]     vcx_q;
  logic                    proto_err_q;

  logic       vc_ok;
  logic       accept;
  logic       legal;
  logic       fwd;
  vc_state_e  cur_state;
  flit_type_e ftype;

  assign ftype         = flit_type_e'(flit_in[FLIT_WIDTH-1 -: FLIT_TYPE_W]);
  assign vc_ok         = ({1'b0, vc_sel} < (VC_W + 1)'(FIFO_NUM));
  assign credit_nz_ext = VC_SPAN'(credit_nz);
  assign flit_ready    = vc_ok && credit_nz_ext[vc_sel];
  assign accept        = flit_valid && flit_ready;
  assign legal         = is_legal(cur_state, ftype);
  assign fwd           = accept && legal;

  // Select the packet state of the addressed VC and decode its credit strobe.
  always_comb begin
    cur_state  = VC_IDLE;
    credit_dec = '0;
    for (int i = 0; i < FIFO_NUM; i++) begin
      if (vc_sel == VC_W'(i)) begin
        cur_state     = vc_state_q[i];
        credit_dec[i] = fwd;
      end
    end
  end

  // One credit counter per VC; only forwarded flits consume a credit.
  for (genvar g = 0; g < FIFO_NUM; g++) begin : g_credit
    credit_counter #(.BUF_DEPTH(BUF_DEPTH)) u_credit (
      .clk      (clk),
      .rst      (rst),
      .inc      (credit_in[g]),
      .dec      (credit_dec[g]),
      .nonzero  (credit_nz[g]),
      .overflow (credit_ovf[g])
    );
  end

  // Per-VC packet FSM: HEAD opens a packet, TAIL closes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_NUM; i++) vc_state_q[i] <= VC_IDLE;
    end else begin
      for (int i = 0; i < FIFO_NUM; i++) begin
        if (credit_dec[i]) begin
          case (ftype)
            FLIT_HEAD: vc_state_q[i] <= VC_ACTIVE;
            FLIT_TAIL: vc_state_q[i] <= VC_IDLE;
            default:   vc_state_q[i] <= vc_state_q[i];
          endcase
        end
      end
    end
  end

  // Link output register: flit held, strobe lasts one cycle per forwarded flit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_q      <= '0;
      vcx_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      vcx_q       <= credit_dec;
      proto_err_q <= proto_err_q | (accept && !legal) | (|credit_ovf);
      if (fwd) flit_q <= flit_in;
    end
  end

  // Busy flags for the allocator mirror the packet FSMs.
  always_comb begin
    vc_busy = '0;
    for (int i = 0; i < FIFO_NUM; i++) vc_busy[i] = (vc_state_q[i] == VC_ACTIVE);
  end

  assign Flit_out     = flit_q;
  assign vcx_out      = vcx_q;
  assign credit_avail = credit_nz;
  assign proto_err    = proto_err_q;

`ifdef OUTPORT_STATS_EN
  logic [31:0] flit_cnt_q;

  // Forwarded-flit counter; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     flit_cnt_q <= '0;
    else if (fwd) flit_cnt_q <= flit_cnt_q + 32'd1;
  end

  assign flit_cnt = flit_cnt_q;
`endif

endmodule

// File: doc/outputport.md
# outputport

Router output port: the transmit end of the link whose far side is the downstream `inputport`. It accepts switch-traversal flits from the crossbar tagged with a VC index, and tracks per-VC credits mirroring the downstream 4-deep VC FIFOs. It drives the flit plus a one-hot VC write strobe (`vcx_out`) that connects directly to the downstream `vcx_in`. It also enforces head/body/tail packet ordering per VC.

## Interface
- `FLIT_WIDTH`, 80: flit width; bits [FLIT_WIDTH-1:FLIT_WIDTH-2] carry the flit type.
- `FIFO_NUM`, 5: number of VCs.
- `BUF_DEPTH`, 4: downstream FIFO depth, which is also the initial credit count.

Ports (clock and reset first):
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `flit_in`  in  FLIT_WIDTH  flit from crossbar.
- `flit_valid`  in  1  `flit_in` is valid this cycle.
- `vc_sel`  in  $clog2(FIFO_NUM)  target VC of `flit_in`.
- `flit_ready`  out  1  combinational; the flit is accepted when `flit_valid && flit_ready`.
- `credit_in`  in  FIFO_NUM  one-cycle pulse per VC; each pulse means one downstream slot was freed.
- `Flit_out`  out  FLIT_WIDTH  registered flit to link.
- `vcx_out`  out  FIFO_NUM  registered one-hot write strobe; zero when idle.
- `credit_avail`  out  FIFO_NUM  bit i = credit[i] != 0; feeds the switch allocator.
- `vc_busy`  out  FIFO_NUM  bit i = VC i is in packet ACTIVE state.
- `proto_err`  out  1  sticky; cleared only by reset.

## Operation
- Flit type encoding: 2'b00 = HEADTAIL (single-flit packet), 2'b01 = HEAD, 2'b10 = BODY, 2'b11 = TAIL.
- Per-VC credit counter, $clog2(BUF_DEPTH+1) bits, reset value BUF_DEPTH.
  - Accepted flit on VC v: credit[v] decrements.
  - `credit_in[v]`: credit[v] increments.
  - Both in the same cycle: credit[v] is unchanged.
  - Increment at BUF_DEPTH with no simultaneous accept: the counter saturates and `proto_err` is set.
- Per-VC packet FSM with states IDLE and ACTIVE:
  - IDLE, HEAD accepted → ACTIVE.
  - ACTIVE, TAIL accepted → IDLE.
  - HEADTAIL in IDLE: forwarded, FSM stays IDLE.
- Legal combinations are HEAD or HEADTAIL in IDLE, and BODY or TAIL in ACTIVE.
- `flit_ready` = (credit[vc_sel] != 0) && (`vc_sel` < FIFO_NUM).
- Accept with an illegal type for the current state: the flit is consumed, no output strobe is driven, no credit is spent, and `proto_err` is set.
- `vc_sel` ≥ FIFO_NUM: `flit_ready` = 0 and the flit is never accepted.
- Only `credit_in` bits below FIFO_NUM are meaningful.

## Timing
- Reset values:
  - `Flit_out` = 0, `vcx_out` = 0.
  - credits = BUF_DEPTH, so `credit_avail` = all ones.
  - `vc_busy` = 0, `proto_err` = 0.
- Latency: a flit accepted at edge N appears on `Flit_out` and `vcx_out` after edge N, for exactly one cycle. `vcx_out` returns to 0 the following cycle unless another flit is accepted.
- Back-to-back: one flit per cycle is sustained while credit remains.
- Credit update: visible in `credit_avail` and `flit_ready` the cycle after the accept or `credit_in` edge. There is no combinational path from `credit_in` to `flit_ready`.
- Reset mid-packet: all FSMs return to IDLE, credits are restored, and any in-flight output strobe is cleared immediately.

## Configuration
- `OUTPORT_STATS_EN` defined: adds output `flit_cnt` [31:0]. The counter increments on each forwarded flit, wraps at 2^32, resets to 0, and does not count dropped illegal flits.
- `OUTPORT_STATS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- `noc_pkg` holds:
  - the `flit_type_e` enum and type-field MSB/LSB constants;
  - the `vc_state_e` enum (IDLE, ACTIVE);
  - default `BUF_DEPTH`.
- Sub-module `credit_counter`, one instance per VC via generate:
  - inputs: inc, dec;
  - outputs: `nonzero`, `overflow`.
- Muxing, the FSMs and the output register stay in the top module.

## Test plan
- Reset, then HEADTAIL on VC2 → next cycle `vcx_out` = 5'b00100, `Flit_out` = input; `credit_avail[2]` stays 1 with credit 3; then `vcx_out` = 0.
- 4 back-to-back flits on VC0 (HEAD, BODY, BODY, TAIL) with no credit return → all forwarded; `credit_avail[0]` = 0, and a 5th flit sees `flit_ready` = 0 and stalls. One `credit_in[0]` pulse → stalled flit accepted one cycle later.
- Accept on VC1 and `credit_in[1]` in the same cycle at credit 2 → credit stays 2; `proto_err` = 0.
- BODY on VC3 while IDLE → no strobe, credit stays 4, `proto_err` = 1 and stays 1 until reset.
- Credit_in[4] pulse with credit at 4 → credit stays 4, `proto_err` = 1.
- HEAD on VC0, then `rst` asserted mid-packet → `vc_busy` = 0, `vcx_out` = 0, all credits = 4; a HEAD afterwards is legal. With `OUTPORT_STATS_EN`, `flit_cnt` reads 0 after reset.
